cra_pipe: RTL and testbench
===========================

# cra_pipe

Parametrised, pipelined carry-ripple adder computing A + B + cin over WIDTH bits with a (WIDTH+1)-bit result. Operands are split into STAGES equal chunks. Each pipeline stage ripples one chunk and registers its carry into the next stage. A valid/ready handshake on both sides lets the block sit between streaming producers and consumers in the arithmetic datapath. It succeeds the fixed 8-bit combinational ripple adder wherever a wider operand or higher clock rate is required.

## Interface
- WIDTH, 32: operand width in bits; must be ≥ 2 and divisible by STAGES.
- STAGES, 4: pipeline depth; chunk width CW = WIDTH/STAGES; 1 ≤ STAGES ≤ WIDTH.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat offered.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in to bit 0.
- sub  in  1  subtract select; the port exists only when CRA_PIPE_SUB_EN is defined.
- out_valid  out  1  result beat available.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH+1  result; sum[WIDTH] is the final carry-out.

## Operation
- Stage k (0..STAGES-1) holds: valid bit v[k]; carry c[k]; low sum bits produced so far; the still-unprocessed high chunks of a and b.
- The input transfer occurs when in_valid && in_ready. Stage 0 then adds chunk 0 of a and b with cin.
- On each advance, stage k adds chunk k of its carried operands to c[k-1]. It appends CW sum bits and registers the chunk carry-out.
- The last stage's registers drive sum directly. out_valid = v[STAGES-1].
- Flow control per stage: rdy[k] = !v[k] || rdy[k+1]; rdy[STAGES] = out_ready; in_ready = rdy[0].
- Bubbles collapse: an empty stage accepts new data even while downstream is stalled.
- Stage k loads when rdy[k] is true. Its v[k] takes the upstream valid; for k = 0 the upstream valid is in_valid.
- When a stalled stage is full, all of its registers hold their values.
- Arithmetic is unsigned modulo 2^(WIDTH+1). sum = a + b + cin exactly; no saturation.
- Beats leave in the order they were accepted. Each accepted beat produces exactly one result.

## Timing
- Latency: a beat accepted at edge N is presented on sum/out_valid after edge N+STAGES-1, provided no stall occurs.
- Throughput: one beat per cycle when out_ready stays high.
- Reset (rst_n low, at any time): all v[k] clear to 0, all data and carry registers clear to 0. Outputs: out_valid=0, sum=0.
- in_ready is 1 during reset. No beat is accepted while rst_n is low.
- In-flight beats are discarded by reset, with no partial output. The first beat after reset release sees an empty pipe.
- Full pipe with out_ready=0: in_ready=0, and sum and out_valid remain stable.
- Simultaneous output accept and input accept on a full pipe: allowed; occupancy stays unchanged.
- in_ready depends combinationally on out_ready through the rdy chain. That chain is the only combinational input-to-output path.
- Carry chain per cycle is CW bits; no single-cycle path spans more than one chunk.

## Configuration
- CRA_PIPE_SUB_EN defined: the sub port exists and is captured with the beat.
  - sub=1 computes a + ~b + 1; cin is ignored; b is inverted at the input.
  - In that case sum[WIDTH]=1 means no borrow.
  - sub=0 behaves as plain addition.
- CRA_PIPE_SUB_EN undefined: no sub port; addition only; no extra registers.

## Structure
- Shared package cra_pkg: function cra_cw(WIDTH, STAGES) returning the chunk width.
  - Also holds a parameter-legality check used by a generate-time assertion.
- Sub-module cra_pipe_stage: one CW-bit ripple chunk plus its valid/carry/data registers and rdy logic.
  - Built internally from the existing FA cell.
  - cra_pipe instantiates it STAGES times with a generate loop.

## Test plan
- Reset check (WIDTH=8, STAGES=2): during and after reset, out_valid=0, sum=0, in_ready=1. After release, a=0x01, b=0x02, cin=0 produces sum=0x003 one cycle after acceptance.
- Carry propagation across chunks (WIDTH=8, STAGES=2): a=0xFF, b=0x01, cin=0 -> sum=0x100. a=0xFF, b=0xFF, cin=1 -> sum=0x1FF.
- Streaming (WIDTH=32, STAGES=4):
  - Stimulus: 100 back-to-back random beats with out_ready=1.
  - Required: one result per cycle, in order, each matching a+b+cin; latency is 3 edges after acceptance.
- Backpressure:
  - Stimulus: hold out_ready=0 until the pipe fills.
  - Required: in_ready falls after 4 accepted beats, and sum stays stable.
  - Then toggle out_ready randomly; no loss or duplication is allowed, and bubbles collapse.
- Reset mid-stream: assert rst_n low with 3 beats in flight -> out_valid=0 immediately, and none of the 3 results ever appear.
- CRA_PIPE_SUB_EN (WIDTH=8, STAGES=2):
  - sub=1, a=0x05, b=0x03 -> sum=0x102.
  - sub=1, a=0x03, b=0x05 -> sum=0x0FE.

Source files
------------

// File: rtl/cra_pkg.sv
// cra_pkg: shared helpers for the pipelined carry-ripple adder.
//   cra_cw        - chunk width (bits rippled per pipeline stage)
//   cra_params_ok - legality of a WIDTH/STAGES pairing, checked at elaboration
//   cra_fa        - one-bit full adder cell, returns {carry_out, sum}
package cra_pkg;

  function automatic int cra_cw(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit cra_params_ok(input int width, input int stages);
    return (width >= 2) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

  function automatic logic [1:0] cra_fa(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

endpackage

// File: rtl/cra_pipe_stage.sv
// cra_pipe_stage: one pipeline stage of cra_pipe. Ripples chunk IDX of the
// carried operands with the incoming carry and registers valid, carry-out,
// operands and partial sum.
//   clk, rst_n        clock, async active-low reset
//   v_i, c_i          upstream valid and carry
//   a_i, b_i, s_i     upstream operands and low sum bits produced so far
//   rdy_i             downstream stage (or consumer) can take data
//   rdy_o             this stage can load this cycle
//   v_o, c_o          registered valid and chunk carry-out
//   a_o, b_o, s_o     registered operands and partial sum
module cra_pipe_stage
  import cra_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CW    = 8,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             v_i,
  input  logic             c_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] s_i,
  input  logic             rdy_i,
  output logic             rdy_o,
  output logic             v_o,
  output logic             c_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] s_o
);

  logic             carry;
  logic [1:0]       fa;
  logic [WIDTH-1:0] s_d;

  // Only CW bits of carry chain live in this stage.
  always_comb begin
    carry = c_i;
    fa    = 2'b00;
    s_d   = s_i;
    for (int i = 0; i < CW; i++) begin
      fa                = cra_fa(a_i[IDX*CW+i], b_i[IDX*CW+i], carry);
      s_d[IDX*CW+i]     = fa[0];
      carry             = fa[1];
    end
  end

  // An empty stage loads regardless of downstream, so bubbles collapse.
  assign rdy_o = !v_o || rdy_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_o <= 1'b0;
      c_o <= 1'b0;
      a_o <= '0;
      b_o <= '0;
      s_o <= '0;
    end else if (rdy_o) begin
      v_o <= v_i;
      c_o <= carry;
      a_o <= a_i;
      b_o <= b_i;
      s_o <= s_d;
    end
  end

endmodule

// File: rtl/cra_pipe.sv
// cra_pipe: pipelined carry-ripple adder, sum = a + b + cin (WIDTH+1 bits),
// STAGES chunks of WIDTH/STAGES bits each, valid/ready on both sides.
//   clk, rst_n              clock, async active-low reset
//   in_valid, in_ready      input handshake
//   a, b, cin               operands and carry-in
//   sub                     subtract select (only with CRA_PIPE_SUB_EN)
//   out_valid, out_ready    output handshake
//   sum                     result, sum[WIDTH] is the carry-out
// Optional feature macro: CRA_PIPE_SUB_EN adds the sub port; subtraction is
// a + ~b + 1, realised by inverting b and forcing the carry-in at the input,
// so the beat carries no extra state.
module cra_pipe
  import cra_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CRA_PIPE_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
);

  localparam int CW = cra_cw(WIDTH, STAGES);

  if (!cra_params_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("cra_pipe: illegal WIDTH/STAGES combination");
  end

  logic [WIDTH-1:0]  b0;
  logic              c0;

`ifdef CRA_PIPE_SUB_EN
  assign b0 = sub ? ~b : b;
  assign c0 = sub | cin;
`else
  assign b0 = b;
  assign c0 = cin;
`endif

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] rdy_up;
  logic [STAGES-1:0] rdy_dn;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic              full_acc;

  // Downstream readiness in closed form: stage k may pass data on when the
  // consumer is ready or any later stage has a hole. Built from registered
  // valids only, so no stage's rdy feeds back into another's.
  always_comb begin
    rdy_dn   = '0;
    full_acc = 1'b1;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy_dn[k] = out_ready || !full_acc;
      full_acc  = full_acc & v_q[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             vi;
    logic             ci;
    logic [WIDTH-1:0] ai;
    logic [WIDTH-1:0] bi;
    logic [WIDTH-1:0] si;

    if (k == 0) begin : g_head
      assign vi = in_valid;
      assign ci = c0;
      assign ai = a;
      assign bi = b0;
      assign si = '0;
    end else begin : g_body
      assign vi = v_q[k-1];
      assign ci = c_q[k-1];
      assign ai = a_q[k-1];
      assign bi = b_q[k-1];
      assign si = s_q[k-1];
    end

    cra_pipe_stage #(
      .WIDTH (WIDTH),
      .CW    (CW),
      .IDX   (k)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .v_i   (vi),
      .c_i   (ci),
      .a_i   (ai),
      .b_i   (bi),
      .s_i   (si),
      .rdy_i (rdy_dn[k]),
      .rdy_o (rdy_up[k]),
      .v_o   (v_q[k]),
      .c_o   (c_q[k]),
      .a_o   (a_q[k]),
      .b_o   (b_q[k]),
      .s_o   (s_q[k])
    );
  end

  assign in_ready  = rdy_up[0];
  assign out_valid = v_q[STAGES-1];
  assign sum       = {c_q[STAGES-1], s_q[STAGES-1]};

  // Last stage's operand copies and the inner rdy taps have no consumer.
  logic tail_unused;
  assign tail_unused = ^{rdy_up, a_q[STAGES-1], b_q[STAGES-1]};

endmodule

// File: tb/tb_cra_pipe.sv
// tb_cra_pipe: bench for cra_pipe with an 8-bit/2-stage and a 32-bit/4-stage
// instance. A queue-based model predicts every result from the operands.
module tb_cra_pipe;

  localparam int S8  = 2;
  localparam int S32 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        v8_in, r8_in, v8_out, r8_out, c8, sub8;
  logic [7:0]  a8, b8;
  logic [8:0]  s8;

  logic        vi, ri, vo, ro, ci, sub32;
  logic [31:0] a32, b32;
  logic [32:0] s32;

  logic es8, es32;
`ifdef CRA_PIPE_SUB_EN
  assign es8  = sub8;
  assign es32 = sub32;
`else
  assign es8  = 1'b0;
  assign es32 = 1'b0;
`endif

  cra_pipe #(.WIDTH(8), .STAGES(S8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v8_in),
    .in_ready  (r8_in),
    .a         (a8),
    .b         (b8),
    .cin       (c8),
`ifdef CRA_PIPE_SUB_EN
    .sub       (sub8),
`endif
    .out_valid (v8_out),
    .out_ready (r8_out),
    .sum       (s8)
  );

  cra_pipe #(.WIDTH(32), .STAGES(S32)) u_dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (vi),
    .in_ready  (ri),
    .a         (a32),
    .b         (b32),
    .cin       (ci),
`ifdef CRA_PIPE_SUB_EN
    .sub       (sub32),
`endif
    .out_valid (vo),
    .out_ready (ro),
    .sum       (s32)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Result of a beat straight from the arithmetic definition.
  function automatic logic [32:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                        input logic c, input logic s);
    logic [32:0] mask, r;
    mask = (33'd1 << w) - 33'd1;
    if (s) r = ({1'b0, x} & mask) + ((~{1'b0, y}) & mask) + 33'd1;
    else   r = ({1'b0, x} & mask) + ({1'b0, y} & mask) + {32'd0, c};
    return r & ((mask << 1) | 33'd1);
  endfunction

  logic [32:0] q8[$];
  logic [32:0] q32[$];
  logic        hold8 = 1'b0, hold32 = 1'b0;
  logic [8:0]  prev8;
  logic [32:0] prev32;
  int          acc32 = 0, dlv32 = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst8_valid", 33'(v8_out), 33'd0);
      chk("rst8_sum",   33'(s8),     33'd0);
      chk("rst8_ready", 33'(r8_in),  33'd1);
      chk("rst32_valid", 33'(vo), 33'd0);
      chk("rst32_sum",   s32,     33'd0);
      chk("rst32_ready", 33'(ri), 33'd1);
      q8.delete();
      q32.delete();
      hold8  = 1'b0;
      hold32 = 1'b0;
    end else begin
      chk("ready8", 33'(r8_in), (q8.size() < S8) ? 33'd1 : 33'(r8_out));
      if (hold8) begin
        chk("hold8_valid", 33'(v8_out), 33'd1);
        chk("hold8_sum", 33'(s8), 33'(prev8));
      end
      if (v8_out) begin
        if (q8.size() == 0) chk("spurious8", 33'(v8_out), 33'd0);
        else if (r8_out) chk("result8", 33'(s8), q8.pop_front());
      end
      hold8 = v8_out && !r8_out;
      prev8 = s8;
      if (v8_in && r8_in) q8.push_back(model(8, {24'd0, a8}, {24'd0, b8}, c8, es8));

      chk("ready32", 33'(ri), (q32.size() < S32) ? 33'd1 : 33'(ro));
      if (hold32) begin
        chk("hold32_valid", 33'(vo), 33'd1);
        chk("hold32_sum", s32, prev32);
      end
      if (vo) begin
        if (q32.size() == 0) chk("spurious32", 33'(vo), 33'd0);
        else if (ro) begin
          chk("result32", s32, q32.pop_front());
          dlv32++;
        end
      end
      hold32 = vo && !ro;
      prev32 = s32;
      if (vi && ri) begin
        q32.push_back(model(32, a32, b32, ci, es32));
        acc32++;
      end
    end
  end

  task automatic lit8(input string nm, input logic [7:0] x, input logic [7:0] y,
                      input logic c, input logic s, input logic [8:0] exp);
    @(posedge clk); #1;
    v8_in = 1'b1; a8 = x; b8 = y; c8 = c; sub8 = s;
    @(posedge clk); #1;
    v8_in = 1'b0;
    chk({nm, "_early"}, 33'(v8_out), 33'd0);
    @(posedge clk); #1;
    chk({nm, "_valid"}, 33'(v8_out), 33'd1);
    chk(nm, 33'(s8), 33'(exp));
  endtask

  task automatic rnd32();
    a32 = $urandom;
    b32 = $urandom;
    ci  = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  nacc;
    logic took;
    rst_n = 1'b0;
    v8_in = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0; sub8 = 1'b0; r8_out = 1'b1;
    vi = 1'b0; a32 = '0; b32 = '0; ci = 1'b0; sub32 = 1'b0; ro = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 33'(v8_out), 33'd0);
    chk("post_rst_sum",   33'(s8),     33'd0);
    chk("post_rst_ready", 33'(r8_in),  33'd1);

    lit8("add_0102", 8'h01, 8'h02, 1'b0, 1'b0, 9'h003);
    lit8("add_ff01", 8'hFF, 8'h01, 1'b0, 1'b0, 9'h100);
    lit8("add_ffff", 8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF);
`ifdef CRA_PIPE_SUB_EN
    lit8("sub_0503", 8'h05, 8'h03, 1'b0, 1'b1, 9'h102);
    lit8("sub_0305", 8'h03, 8'h05, 1'b1, 1'b1, 9'h0FE);
    lit8("sub0_add", 8'h10, 8'h20, 1'b1, 1'b0, 9'h031);
`endif

    // Streaming: 100 back-to-back beats, result 3 edges after acceptance.
    for (int i = 0; i <= 104; i++) begin
      @(posedge clk); #1;
      if (i >= 4 && i <= 103) chk("stream_valid", 33'(vo), 33'd1);
      if (i == 3 || i == 104) chk("stream_latency", 33'(vo), 33'd0);
      if (i == 4) chk("stream_first", s32, 33'h1_0000_0001);
      if (i < 100) begin
        vi = 1'b1;
        if (i == 0) begin
          a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001; ci = 1'b1;
        end else rnd32();
      end else vi = 1'b0;
    end

    // Backpressure: fill the pipe with the consumer stalled.
    ro = 1'b0; nacc = 0;
    vi = 1'b1; a32 = 32'h8000_0000; b32 = 32'h8000_0000; ci = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); took = ri;
      @(posedge clk); #1;
      if (took) begin
        nacc++;
        rnd32();
      end
    end
    chk("bp_accepted", 33'(nacc), 33'd4);
    chk("bp_in_ready", 33'(ri), 33'd0);
    chk("bp_valid", 33'(vo), 33'd1);
    chk("bp_sum", s32, 33'h1_0000_0000);

    // Random valid/ready toggling; operands held until taken.
    for (int i = 0; i < 80; i++) begin
      @(negedge clk); took = vi && ri;
      @(posedge clk); #1;
      if (took || !vi) begin
        vi = 1'($urandom_range(0, 1));
        rnd32();
      end
      ro = 1'($urandom_range(0, 1));
    end
    vi = 1'b0; ro = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("no_loss", 33'(dlv32), 33'(acc32));
    chk("drained", 33'(vo), 33'd0);

    // Reset with three beats in flight.
    for (int j = 0; j < 3; j++) begin
      vi = 1'b1;
      rnd32();
      @(posedge clk); #1;
    end
    vi = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", 33'(vo), 33'd0);
    chk("rstmid_sum", s32, 33'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("rstmid_gone", 33'(vo), 33'd0);
    end

    // First beat after reset sees an empty pipe.
    vi = 1'b1; a32 = 32'd5; b32 = 32'd7; ci = 1'b1;
    @(posedge clk); #1;
    vi = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("after_rst_early", 33'(vo), 33'd0);
    @(posedge clk); #1;
    chk("after_rst_valid", 33'(vo), 33'd1);
    chk("after_rst_sum", s32, 33'h0_0000_000D);
    repeat (3) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
